// File: rtl/wb_button_ctrl.sv
// N-channel push-button front end: 2-FF sync, tick-sampled debounce, edge detect,
// W1C pending register with maskable interrupt, Wishbone classic slave port.
module wb_button_ctrl #(
  parameter int N_CH       = 5,
  parameter int SAMPLE_DIV = 1050000,
  parameter int STABLE_CNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic [3:0]      wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic [N_CH-1:0] level_o,
  output logic            intr
);

  localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;

  localparam logic [1:0] ADR_STATUS  = 2'd0;
  localparam logic [1:0] ADR_PENDING = 2'd1;
  localparam logic [1:0] ADR_IRQ_EN  = 2'd2;
  localparam logic [1:0] ADR_EDGE    = 2'd3;

  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;
  logic [N_CH-1:0] level_w;
  logic [N_CH-1:0] level_prev_reg;
  logic [N_CH-1:0] pending_reg;
  logic [N_CH-1:0] pending_next;
  logic [N_CH-1:0] irq_en_reg;
  logic [N_CH-1:0] rise_en_reg;
  logic [N_CH-1:0] fall_en_reg;
  logic [N_CH-1:0] edge_ev;
  logic [N_CH-1:0] clr_mask;
  logic [TW-1:0]   tick_cnt_reg;
  logic            tick;
  logic            ack_reg;
  logic            intr_reg;
  logic [31:0]     dat_reg;
  logic [31:0]     rdata;
  logic            access;
  logic            wr_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign tick = (tick_cnt_reg == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // One debouncer per channel; each owns its level and run counter.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic          level_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (tick) begin
          if (sync2_reg[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(STABLE_CNT - 1)) begin
            level_reg <= sync2_reg[gi];
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign level_w[gi] = level_reg;
    end
  endgenerate

  assign level_o = level_w;
  assign edge_ev = (level_w & ~level_prev_reg & rise_en_reg)
                 | (~level_w & level_prev_reg & fall_en_reg);

  assign access = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign wr_en  = access & wb_we_i & (wb_sel_i[1:0] == 2'b11);

  always_comb begin
    clr_mask = '0;
    if (wr_en && (wb_adr_i[3:2] == ADR_PENDING)) begin
      clr_mask = wb_dat_i[N_CH-1:0];
    end
    // A new event outranks a simultaneous clear of the same bit.
    pending_next = (pending_reg & ~clr_mask) | edge_ev;
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      ADR_STATUS:  rdata = 32'(level_w);
      ADR_PENDING: rdata = 32'(pending_reg);
      ADR_IRQ_EN:  rdata = 32'(irq_en_reg);
      ADR_EDGE:    rdata = (32'(fall_en_reg) << 16) | 32'(rise_en_reg);
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_prev_reg <= '0;
      pending_reg    <= '0;
      irq_en_reg     <= '0;
      rise_en_reg    <= '1;
      fall_en_reg    <= '0;
      ack_reg        <= 1'b0;
      dat_reg        <= '0;
      intr_reg       <= 1'b0;
    end else begin
      level_prev_reg <= level_w;
      pending_reg    <= pending_next;
      intr_reg       <= |(pending_reg & irq_en_reg);
      ack_reg        <= access;
      dat_reg        <= (access && !wb_we_i) ? rdata : 32'd0;
      if (wr_en && (wb_adr_i[3:2] == ADR_IRQ_EN)) begin
        irq_en_reg <= wb_dat_i[N_CH-1:0];
      end
      if (wr_en && (wb_adr_i[3:2] == ADR_EDGE)) begin
        rise_en_reg <= wb_dat_i[N_CH-1:0];
        fall_en_reg <= wb_dat_i[16 +: N_CH];
      end
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
  assign intr     = intr_reg;

endmodule
